// File: rtl/gate_tt_sequencer_if.sv
// Stimulus/result bundle between the truth-table sequencer and its user.
// The slave side is the sequencer; the master side is whoever starts sweeps,
// supplies the gate output and consumes the results.
//   start, abort    sweep control (master -> slave)
//   dut_y           output C of the gate under test (master -> slave)
//   vec             gate input vector (slave -> master)
//   busy, done      sweep status (slave -> master)
//   pass, err_count, fail_valid, first_fail_vec, result_bits
//                   sweep results (slave -> master)
interface gate_tt_sequencer_if #(
  parameter int N_IN = 2
);
  logic                     start;
  logic                     abort;
  logic                     dut_y;
  logic [N_IN-1:0]          vec;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [N_IN:0]            err_count;
  logic                     fail_valid;
  logic [N_IN-1:0]          first_fail_vec;
  logic [(1<<N_IN)-1:0]     result_bits;

  modport master (
    output start, abort, dut_y,
    input  vec, busy, done, pass, err_count, fail_valid, first_fail_vec, result_bits
  );

  modport slave (
    input  start, abort, dut_y,
    output vec, busy, done, pass, err_count, fail_valid, first_fail_vec, result_bits
  );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 2^N_IN-row combinational gate check.
// On start it walks vec through 0..2^N_IN-1, holds each vector SETTLE cycles,
// samples dut_y in the following cycle and compares it with EXP_TABLE[vec].
// Reports pass, mismatch count and the first failing vector.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    gate_tt_sequencer_if.slave (start/abort/dut_y in, results out)
// Optional feature macro: GATE_TT_TRACE_EN -- when defined, result_bits
// records the measured dut_y per vector; otherwise result_bits is tied to 0.
module gate_tt_sequencer #(
  parameter int                   N_IN      = 2,
  parameter int                   SETTLE    = 1,
  parameter logic [(1<<N_IN)-1:0] EXP_TABLE = 'b0110
) (
  input  logic                clk,
  input  logic                reset,
  gate_tt_sequencer_if.slave  bus
);
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [3:0]      SET_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          state;
  logic [3:0]      settle_cnt;
  logic [N_IN-1:0] vec;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] first_fail_vec;
  logic            mismatch;

  assign mismatch = (bus.dut_y != EXP_TABLE[vec]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      vec            <= '0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start beats abort here; abort has no meaning while idle
          if (bus.start) begin
            state          <= DRIVE;
            vec            <= '0;
            settle_cnt     <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            state <= IDLE;
            pass  <= 1'b0;
          end else if (settle_cnt == SET_LAST) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          // an abort skips the compare so counters keep their pre-abort values
          if (bus.abort) begin
            state <= IDLE;
            pass  <= 1'b0;
          end else begin
            if (mismatch) begin
              err_count <= err_count + 1'b1;
              if (!fail_valid) begin
                fail_valid     <= 1'b1;
                first_fail_vec <= vec;
              end
            end
            if (vec == LAST_VEC) begin
              state <= DONE;
              pass  <= (err_count == '0) && !mismatch;
            end else begin
              vec        <= vec + 1'b1;
              settle_cnt <= '0;
              state      <= DRIVE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATE_TT_TRACE_EN
  logic [(1<<N_IN)-1:0] trace;

  always_ff @(posedge clk) begin
    if (reset) begin
      trace <= '0;
    end else if (state == IDLE && bus.start) begin
      trace <= '0;
    end else if (state == SAMPLE && !bus.abort) begin
      trace[vec] <= bus.dut_y;
    end
  end

  assign bus.result_bits = trace;
`else
  assign bus.result_bits = '0;
`endif

  assign bus.vec            = vec;
  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
  assign bus.pass           = pass;
  assign bus.err_count      = err_count;
  assign bus.fail_valid     = fail_valid;
  assign bus.first_fail_vec = first_fail_vec;
endmodule

// File: doc/gate_tt_sequencer.md
# gate_tt_sequencer

Self-checking truth-table stimulus sequencer placed directly upstream of a 2-input gate under test, defaulting to the XNAND gate. On a start pulse it drives every input vector onto the gate's A/B inputs and waits a programmable settle time. It then samples the gate output C and compares it against a parameterised expected truth table. It reports done, pass/fail, mismatch count and the first failing vector, and is used as the lab's on-chip checker for gate-level experiments.

## Interface
- `N_IN`, 2: number of gate inputs; vector count is 2^N_IN.
- `SETTLE`, 1: cycles each vector is held before sampling; legal range 1..15.
- `EXP_TABLE`, 4'b0110: expected output, width 2^N_IN. Bit i is the expected value for vector i. The default is XNAND, which equals XOR.
- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `abort`  in  1  terminate a sweep in progress.
- `dut_y`  in  1  gate output (C of the gate under test).
- `vec`  out  N_IN  gate input vector; for N_IN=2, vec[1] drives A and vec[0] drives B.
- `busy`  out  1  high in DRIVE, SAMPLE and DONE.
- `done`  out  1  one-cycle pulse, high while in DONE.
- `pass`  out  1  high when the last completed sweep had zero mismatches; held until the next start.
- `err_count`  out  N_IN+1  mismatch count for the current or last sweep.
- `fail_valid`  out  1  high when `first_fail_vec` holds a captured vector.
- `first_fail_vec`  out  N_IN  first vector that mismatched.
- `result_bits`  out  2^N_IN  sampled `dut_y` per vector (see Configuration).

## Operation
- **States:** IDLE, DRIVE, SAMPLE, DONE. The state is held in registers, and all outputs are registered or decoded from state.
- **IDLE, start=1 at an edge:**
  - Go to DRIVE.
  - vec<=0, settle_cnt<=0.
  - err_count<=0, fail_valid<=0, first_fail_vec<=0, pass<=0, result_bits<=0.
- **DRIVE:**
  - If settle_cnt==SETTLE-1, go to SAMPLE.
  - Otherwise settle_cnt++.
  - vec is held stable throughout.
- **SAMPLE:**
  - Compare dut_y with EXP_TABLE[vec].
  - On mismatch: err_count++ (cannot saturate; the maximum is 2^N_IN). If fail_valid==0, set first_fail_vec<=vec and fail_valid<=1.
  - If vec==2^N_IN-1, go to DONE and set pass<=(mismatch-free sweep, including this sample).
  - Otherwise vec++, settle_cnt<=0, and return to DRIVE.
- **DONE:** done=1 for exactly one cycle, then return to IDLE.
- **Boundary conditions:**
  - **start while busy:** ignored, with no restart.
  - **abort in DRIVE or SAMPLE:** go to IDLE next edge; done stays 0 and pass<=0. err_count, fail_valid and first_fail_vec keep their values.
  - **abort in DONE or IDLE:** no effect.
  - **abort and start together in IDLE:** start wins.
  - **vec after a sweep:** holds its last value (2^N_IN-1) in IDLE, with no wrap to 0 until the next start.
  - **reset:** has priority over all inputs at any time, including mid-sweep.
  - **Reset values:** state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0, result_bits=0.

## Timing
- The start edge is e0; DRIVE for vector 0 begins in the cycle after e0.
- Each vector occupies SETTLE+1 cycles: SETTLE in DRIVE plus 1 in SAMPLE.
- done is high in the cycle following edge e0 + 2^N_IN·(SETTLE+1). With defaults this is 8 cycles after e0; with SETTLE=2 it is 12 cycles.
- pass, err_count and fail flags are final in the same cycle that done is high.
- dut_y is sampled in the last cycle of each vector's window, at least SETTLE cycles after vec changed. The gate is combinational, so no extra latency applies.
- A back-to-back start is accepted in the first IDLE cycle after DONE, giving a minimum of 1 idle cycle between sweeps.

## Configuration
- Macro `GATE_TT_TRACE_EN`.
- **Defined:** in SAMPLE, result_bits[vec]<=dut_y, so after DONE result_bits holds the measured truth table of the gate. It is cleared on start and reset.
- **Undefined:** the result_bits port is present but constantly 0, and no trace registers are synthesised.
- Pass/fail behaviour is identical in both builds.

## Test plan
- **Correct XNAND attached, defaults, start pulse:** vec steps 0,1,2,3 every 2 cycles. done is high 8 cycles after the start edge, with pass=1, err_count=0 and fail_valid=0. With the trace macro defined, result_bits=4'b0110.
- **Gate replaced by XNOR (inverted output), SETTLE=2:** done arrives 12 cycles after start, with pass=0, err_count=3'd4, fail_valid=1 and first_fail_vec=2'b00.
- **dut_y forced to 0:** mismatches occur on vectors 1 and 2, giving err_count=2, first_fail_vec=2'b01 and pass=0.
- **start re-pulsed mid-sweep, then abort during vector 2's DRIVE:** the re-pulsed start is ignored. The abort returns the block to IDLE the next cycle; done never pulses, pass=0, busy=0.
- **reset asserted during SAMPLE of vector 1:** the next cycle shows all reset values (vec=0, err_count=0). A subsequent start completes a full, correct sweep.
- **Two back-to-back sweeps:** the second start is given in the first IDLE cycle after done. The second sweep is accepted immediately, and err_count is cleared at its start edge.
